md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide controller for the single-cycle CPU.
- Accepts MULT/MULTU/DIV/DIVU from the control unit, runs an iterative shift-add multiply or restoring divide, and produces HI/LO results.
- Drives the `busy` stall to the PC unit, so the PC holds the current instruction until the result is committed.
- Replaces the combinational mul/div path feeding the Hi/Lo registers.

Parameters:
- WIDTH, 32, operand width. RUN phase lasts WIDTH cycles. Counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  operation request; level; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start.
- b  in  WIDTH  rt operand (multiplier / divisor); sampled with start.
- busy  out  1  stall request to PC; combinational.
- done  out  1  one-cycle pulse; hi/lo valid from this cycle.
- hi  out  WIDTH  product high word / remainder; registered.
- lo  out  WIDTH  product low word / quotient; registered.
- div_zero  out  1  set when the last completed op was a divide by 0; registered.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; hi=0, lo=0, div_zero=0, counter=0.
  - busy=0 and done=0 while rst is low.
  - Reset mid-operation aborts the operation with no partial hi/lo update.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - On start=1: latch op, a, b, sign(a), sign(b); go to PREP.
  - busy = start (combinational), so the PC stalls in the issue cycle itself.
- PREP (1 cycle):
  - Signed ops: take magnitudes of a and b. Unsigned ops: use raw values.
  - Load counter=WIDTH and clear accumulators; go to RUN.
  - Divide with b==0: load hi=a (raw), lo=all-ones, div_zero=1; go directly to DONE.
- RUN (WIDTH cycles):
  - Multiply: 2*WIDTH-bit accumulator. Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half; then shift right 1.
  - Divide: restoring. Shift {rem,quot} left 1; trial subtract the divisor from a WIDTH+1-bit remainder. If non-negative, keep it and set quot LSB=1.
  - Counter decrements each cycle; leave RUN after the cycle in which counter reaches 1.
- FIX (1 cycle):
  - MULT: if sign(a)^sign(b), two's-complement negate the 2*WIDTH product.
  - DIV: negate the quotient if signs differ; negate the remainder if sign(a)=1. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Write hi/lo (hi = high word / remainder, lo = low word / quotient); div_zero=0. Go to DONE.
- DONE (1 cycle):
  - done=1, busy=0; the PC advances this cycle.
  - start is ignored here, even if still high from the held instruction.
  - Next state IDLE.
- busy = (IDLE & start) | PREP | RUN | FIX.
- Latency (start sampled at cycle 0, WIDTH=32):
  - Normal op: busy cycles 0–34, done at cycle 35.
  - Divide by zero: busy cycles 0–1, done at cycle 2.
- Arithmetic rules:
  - 0x80000000 / -1 (DIV) gives lo=0x80000000, hi=0 through the magnitude path. No trap, no flag.
  - MULT of 0x80000000*0x80000000 gives hi=0x40000000, lo=0.
- Outside FIX/PREP writes, hi/lo/div_zero hold their previous values indefinitely.
- Operand inputs may change after cycle 0 without affecting the result.

Test Plan:
- Basic multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at cycle 35 exactly, hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 0–34 only.
- Signed multiply: MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also MULT 0x80000000*0x80000000 → hi=0x40000000, lo=0.
- Signed divide: DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIVU a=100, b=0 → done at cycle 2, hi=100, lo=0xFFFFFFFF, div_zero=1. A following DIVU 9/3 clears div_zero, giving lo=3, hi=0.
- Held start: keep start=1 and op=MULTU continuously across DONE → exactly one done pulse per 36-cycle window. A second op starts only from IDLE (cycle 36), and the DONE cycle never re-triggers.
- Mid-run reset: assert rst=0 at cycle 10 of a DIV → busy=0, done=0, hi=lo=0 immediately. After release, a new MULT 6*7 → lo=42, hi=0 at the correct latency.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer
//   Multi-cycle multiply/divide controller for the single-cycle CPU.
//   Runs MULT/MULTU with an iterative shift-add multiplier and DIV/DIVU
//   with a restoring divider, then commits HI/LO. It stalls the PC through
//   `busy` until the result is written.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   start     operation request (level), sampled only in IDLE
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU, sampled with start
//   a, b      rs / rt operands, sampled with start
//   busy      combinational stall request to the PC
//   done      one-cycle pulse, hi/lo are valid from this cycle
//   hi, lo    product high/low word, or remainder/quotient (registered)
//   div_zero  last completed op was a divide by zero (registered)
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // {upper, lower} working register
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dz_q, dz_d;

    // Operation decode from the latched opcode.
    logic is_div, is_signed, neg_a, neg_b;
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign neg_a     = is_signed & a_q[WIDTH-1];
    assign neg_b     = is_signed & b_q[WIDTH-1];

    logic [WIDTH-1:0] mag_a, mag_b;
    assign mag_a = neg_a ? -a_q : a_q;
    assign mag_b = neg_b ? -b_q : b_q;

    // Multiply step: add the multiplicand into the upper half when the
    // multiplier LSB is set, keeping the carry so the right shift is exact.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide step: upper half is the remainder, lower half shifts the
    // dividend out and the quotient bits in. The remainder stays below the
    // divisor, so the shifted value always fits in WIDTH+1 bits.
    logic [WIDTH:0]     div_sh, div_trial;
    logic [2*WIDTH-1:0] div_step;
    assign div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_sh - {1'b0, opnd_q};
    assign div_step  = div_trial[WIDTH]
                     ? {div_sh[WIDTH-1:0],    acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign fix-up: quotient truncates toward zero, remainder follows the
    // dividend. The most negative dividend over -1 wraps back to itself.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = (neg_a ^ neg_b) ? -acc_q : acc_q;
    assign quot_fix = (neg_a ^ neg_b) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no
        // path through the case statement can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (is_div && (b_q == '0)) begin
                    hi_d    = a_q;
                    lo_d    = '1;
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CW'(WIDTH);
                    acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    opnd_d  = is_div ? mag_b : mag_a;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = is_div ? div_step : mul_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            // start is deliberately ignored here so a held instruction
            // cannot re-trigger before the PC has advanced.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // busy is gated by rst so the PC is never stalled while in reset, even
    // if start is already high.
    assign busy = rst && (((state_q == S_IDLE) && start) ||
                          (state_q == S_PREP) ||
                          (state_q == S_RUN)  ||
                          (state_q == S_FIX));
    assign done     = (state_q == S_DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule
